// File: rtl/nfc_atom_timed_idle_pkg.sv
// Pin-bundle encodings shared by the NFC primitive-command atoms.
// Every atom drives the same PHY pin bundle, so the idle levels live here
// and are imported wherever an atom needs to park the bus.
package nfc_atom_timed_idle_pkg;

    // RE/WE 4-phase patterns for a quiet bus (strobes parked high).
    localparam logic [3:0]  WRITE_IDLE  = 4'b0011;
    localparam logic [3:0]  READ_IDLE   = 4'b0011;

    // Output-enable polarity of the PHY pads (active-low).
    localparam logic        OUT_ENABLE  = 1'b0;
    localparam logic        OUT_DISABLE = 1'b1;

    // Data and strobe levels while the bus is idle.
    localparam logic [7:0]  DQS_IDLE    = 8'h00;
    localparam logic [31:0] DQ_IDLE     = 32'h0000_0000;

    // Latch enables inactive.
    localparam logic [3:0]  ALE_IDLE    = 4'h0;
    localparam logic [3:0]  CLE_IDLE    = 4'h0;

endpackage

// File: rtl/nfc_atom_timed_idle_rb.sv
// Per-way R/B# synchronizer: an RBSyncStages-deep flop chain for every way.
// The chains clear to 0 (busy) on reset so nothing looks ready until the
// real pin level has propagated through the chain.
module nfc_rb_synchronizer #(
    parameter int NumberOfWays = 4,
    parameter int RBSyncStages = 2
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic [NumberOfWays-1:0] iReadyBusy,
    output logic [NumberOfWays-1:0] oReadyBusySync
);

    genvar gi;
    generate
        for (gi = 0; gi < NumberOfWays; gi++) begin : g_way
            logic [RBSyncStages-1:0] chain_q;

            // Shift the raw pin level through the synchronizer chain.
            always_ff @(posedge iSystemClock or negedge iReset) begin
                if (!iReset) begin
                    chain_q <= '0;
                end else begin
                    chain_q <= {chain_q[RBSyncStages-2:0], iReadyBusy[gi]};
                end
            end

            assign oReadyBusySync[gi] = chain_q[RBSyncStages-1];
        end
    endgenerate

endmodule

// File: rtl/nfc_atom_timed_idle.sv
// Timed idle atom: parks the NAND bus in its idle pin state for a programmed
// number of cycles, optionally ending early once every selected way reports
// ready on R/B#, and flags a timeout when an R/B# wait runs out of cycles.
module nfc_atom_timed_idle
    import nfc_atom_timed_idle_pkg::*;
#(
    parameter int NumberOfWays = 4,
    parameter int TimerWidth   = 16,
    parameter int RBSyncStages = 2
) (
    input  logic                      iSystemClock,
    input  logic                      iReset,
    input  logic                      iStart,
    input  logic [NumberOfWays-1:0]   iTargetWay,
    input  logic [TimerWidth-1:0]     iNumOfCycles,
    input  logic                      iCEHold,
    input  logic                      iWaitRB,
    input  logic [NumberOfWays-1:0]   iReadyBusy,
    output logic                      oReady,
    output logic                      oLastStep,
    output logic                      oTimeout,
    output logic                      oDQSOutEnable,
    output logic                      oDQOutEnable,
    output logic [7:0]                oDQStrobe,
    output logic [31:0]               oDQ,
    output logic [2*NumberOfWays-1:0] oChipEnable,
    output logic [3:0]                oReadEnable,
    output logic [3:0]                oWriteEnable,
    output logic [3:0]                oAddressLatchEnable,
    output logic [3:0]                oCommandLatchEnable
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic [TimerWidth-1:0] COUNT_ONE = TimerWidth'(1);

    state_e                    state_q,   state_d;
    logic [TimerWidth-1:0]     count_q,   count_d;
    logic [NumberOfWays-1:0]   way_q,     way_d;
    logic                      cehold_q,  cehold_d;
    logic                      waitrb_q,  waitrb_d;
    logic                      timeout_q, timeout_d;
    logic [2*NumberOfWays-1:0] ce_q,      ce_d;

    logic [NumberOfWays-1:0]   rb_sync;
    logic                      rb_all_ready;
    logic                      last_step;

    nfc_rb_synchronizer #(
        .NumberOfWays (NumberOfWays),
        .RBSyncStages (RBSyncStages)
    ) u_rb_sync (
        .iSystemClock   (iSystemClock),
        .iReset         (iReset),
        .iReadyBusy     (iReadyBusy),
        .oReadyBusySync (rb_sync)
    );

    // Unselected ways are masked to "ready", so an empty way set is
    // immediately ready and ends an R/B# wait after one hold cycle.
    assign rb_all_ready = &(rb_sync | ~way_q);

    // State, counter, latched command and registered CE pins.
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            way_q     <= '0;
            cehold_q  <= 1'b0;
            waitrb_q  <= 1'b0;
            timeout_q <= 1'b0;
            ce_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            way_q     <= way_d;
            cehold_q  <= cehold_d;
            waitrb_q  <= waitrb_d;
            timeout_q <= timeout_d;
            ce_q      <= ce_d;
        end
    end

    // Next-state logic: accept a start in IDLE, count down in HOLD, leave
    // HOLD on ready (takes priority) or on the last counted cycle.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        way_d     = way_q;
        cehold_d  = cehold_q;
        waitrb_d  = waitrb_q;
        timeout_d = timeout_q;
        ce_d      = '0;
        last_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d   = ST_HOLD;
                    way_d     = iTargetWay;
                    // A zero length still gives one hold cycle.
                    count_d   = (iNumOfCycles == '0) ? COUNT_ONE : iNumOfCycles;
                    cehold_d  = iCEHold;
                    waitrb_d  = iWaitRB;
                    timeout_d = 1'b0;
                    ce_d      = iCEHold ? {iTargetWay, iTargetWay} : '0;
                end
            end

            ST_HOLD: begin
                count_d = count_q - COUNT_ONE;
                if (waitrb_q && rb_all_ready) begin
                    last_step = 1'b1;
                    state_d   = ST_IDLE;
                    count_d   = '0;
                end else if (count_q == COUNT_ONE) begin
                    last_step = 1'b1;
                    state_d   = ST_IDLE;
                    count_d   = '0;
                    // Ran out of cycles while still waiting for R/B#.
                    timeout_d = waitrb_q;
                end else begin
                    ce_d = cehold_q ? {way_q, way_q} : '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign oReady    = (state_q == ST_IDLE);
    assign oLastStep = last_step;
    assign oTimeout  = timeout_q;

    // Only CE varies; every other pin sits at its idle encoding.
    assign oChipEnable         = ce_q;
    assign oDQSOutEnable       = OUT_ENABLE;
    assign oDQOutEnable        = OUT_ENABLE;
    assign oDQStrobe           = DQS_IDLE;
    assign oDQ                 = DQ_IDLE;
    assign oReadEnable         = READ_IDLE;
    assign oWriteEnable        = WRITE_IDLE;
    assign oAddressLatchEnable = ALE_IDLE;
    assign oCommandLatchEnable = CLE_IDLE;

endmodule

// File: tb/tb_nfc_atom_timed_idle.sv
// Directed bench for the timed idle atom: count mode, zero length, R/B#
// early exit, timeout, ignored starts, multi-way wait and async reset.
module tb_nfc_atom_timed_idle;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  way;
    logic [15:0] ncyc;
    logic        cehold;
    logic        waitrb;
    logic [3:0]  rb;

    logic        ready;
    logic        last;
    logic        timeout;
    logic        dqs_oe;
    logic        dq_oe;
    logic [7:0]  dqs;
    logic [31:0] dq;
    logic [7:0]  ce;
    logic [3:0]  re;
    logic [3:0]  we;
    logic [3:0]  ale;
    logic [3:0]  cle;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc;
    int got;

    nfc_atom_timed_idle #(
        .NumberOfWays (4),
        .TimerWidth   (16),
        .RBSyncStages (2)
    ) dut (
        .iSystemClock        (clk),
        .iReset              (rst_n),
        .iStart              (start),
        .iTargetWay          (way),
        .iNumOfCycles        (ncyc),
        .iCEHold             (cehold),
        .iWaitRB             (waitrb),
        .iReadyBusy          (rb),
        .oReady              (ready),
        .oLastStep           (last),
        .oTimeout            (timeout),
        .oDQSOutEnable       (dqs_oe),
        .oDQOutEnable        (dq_oe),
        .oDQStrobe           (dqs),
        .oDQ                 (dq),
        .oChipEnable         (ce),
        .oReadEnable         (re),
        .oWriteEnable        (we),
        .oAddressLatchEnable (ale),
        .oCommandLatchEnable (cle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
            $display("[TB] ok   %s = %0h", tag, obs);
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive a start request; the caller ticks to have it accepted.
    task automatic issue(input logic [3:0] w, input logic [15:0] n,
                         input logic ch, input logic wr);
        start  = 1'b1;
        way    = w;
        ncyc   = n;
        cehold = ch;
        waitrb = wr;
    endtask

    // Count hold cycles until oLastStep, optionally raising R/B# bits at a
    // given cycle. got stays 0 if the bound expires.
    task automatic run_hold(input int limit, input int rb_cycle, input logic [3:0] rb_val);
        cyc = 1;
        got = 0;
        while (got == 0 && cyc <= limit) begin
            if (last) begin
                got = cyc;
            end else begin
                if (cyc == rb_cycle) rb = rb_val;
                tick();
                cyc++;
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        way    = 4'h0;
        ncyc   = 16'h0;
        cehold = 1'b0;
        waitrb = 1'b0;
        rb     = 4'h0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_ready",   ready,   1'b1);
        check("rst_last",    last,    1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_ce",      ce,      8'h00);
        check("rst_pins",    {dqs_oe, dq_oe, dqs, dq, re, we, ale, cle},
              {1'b0, 1'b0, 8'h00, 32'h0, 4'b0011, 4'b0011, 4'h0, 4'h0});
        rst_n = 1'b1;
        tick();

        // Count mode, way 1, N=3, CE held
        issue(4'b0010, 16'd3, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        check("t1_c1_ce",    ce,    8'b0010_0010);
        check("t1_c1_ready", ready, 1'b0);
        check("t1_c1_last",  last,  1'b0);
        tick();
        check("t1_c2_ce",    ce,    8'b0010_0010);
        check("t1_c2_last",  last,  1'b0);
        tick();
        check("t1_c3_ce",    ce,    8'b0010_0010);
        check("t1_c3_last",  last,  1'b1);
        check("t1_c3_pins",  {re, we, dq}, {4'b0011, 4'b0011, 32'h0});
        tick();
        check("t1_c4_ready", ready, 1'b1);
        check("t1_c4_ce",    ce,    8'h00);
        check("t1_c4_last",  last,  1'b0);

        // N=0 treated as 1, CE not held
        issue(4'b0100, 16'd0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        check("t2_c1_ce",    ce,    8'h00);
        check("t2_c1_last",  last,  1'b1);
        check("t2_c1_ready", ready, 1'b0);
        tick();
        check("t2_c2_ready", ready, 1'b1);
        check("t2_c2_last",  last,  1'b0);

        // R/B# early exit: ready rises at cycle 10, seen 2 cycles later
        issue(4'b0001, 16'd100, 1'b1, 1'b1);
        tick();
        start = 1'b0;
        run_hold(120, 10, 4'b0001);
        check("t3_exit_cycle", got, 12);
        tick();
        check("t3_ready",   ready,   1'b1);
        check("t3_timeout", timeout, 1'b0);

        // Timeout: R/B# stays busy for the whole N=20
        rb = 4'h0;
        repeat (3) tick();
        issue(4'b0001, 16'd20, 1'b1, 1'b1);
        tick();
        start = 1'b0;
        run_hold(40, 0, 4'h0);
        check("t4_exit_cycle", got, 20);
        check("t4_timeout_during", timeout, 1'b0);
        tick();
        check("t4_ready",   ready,   1'b1);
        check("t4_timeout", timeout, 1'b1);

        // Start during HOLD is ignored; new start clears the timeout
        issue(4'b0010, 16'd5, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        check("t5_timeout_cleared", timeout, 1'b0);
        check("t5_c1_ce", ce, 8'b0010_0010);
        tick();
        issue(4'b1000, 16'd2, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        check("t5_c3_ce",   ce,   8'b0010_0010);
        check("t5_c3_last", last, 1'b0);
        tick();
        check("t5_c4_last", last, 1'b0);
        tick();
        check("t5_c5_last", last, 1'b1);
        check("t5_c5_ce",   ce,   8'b0010_0010);
        tick();
        check("t5_c6_ready", ready, 1'b1);
        check("t5_c6_ce",    ce,    8'h00);

        // Multi-way wait: way 0 ready early, way 2 ready at cycle 5
        rb = 4'b0001;
        repeat (3) tick();
        issue(4'b0101, 16'd50, 1'b1, 1'b1);
        tick();
        start = 1'b0;
        check("t6_ce", ce, 8'b0101_0101);
        run_hold(60, 5, 4'b0101);
        check("t6_exit_cycle", got, 7);
        tick();
        check("t6_ready",   ready,   1'b1);
        check("t6_timeout", timeout, 1'b0);

        // Asynchronous reset in the middle of HOLD
        issue(4'b1111, 16'd50, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        tick();
        check("t7_ce_before", ce, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_ce_async",    ce,    8'h00);
        check("t7_ready_async", ready, 1'b1);
        check("t7_last_async",  last,  1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Empty way set in R/B# mode counts as ready: one cycle, no timeout
        rb = 4'h0;
        issue(4'b0000, 16'd10, 1'b1, 1'b1);
        tick();
        start = 1'b0;
        check("t8_c1_last", last, 1'b1);
        tick();
        check("t8_ready",   ready,   1'b1);
        check("t8_timeout", timeout, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/nfc_atom_timed_idle.md
Name: nfc_atom_timed_idle

Overview:
Parametrised successor to the combinational command-idle atom. It holds the NAND bus in the idle pin state for a programmed number of cycles. It can optionally end early when the target way(s) report ready on R/B#, and it reports timeout if they do not. It sits beside the other NFC atoms under the primitive-command mux and drives the same PHY pin-bundle encoding.

Parameters:
NumberOfWays, 4, number of NAND ways (CE / R/B# lines)
TimerWidth, 16, width of the cycle counter and of iNumOfCycles
RBSyncStages, 2, synchronizer depth on iReadyBusy (minimum 2)

Ports:
iSystemClock  in  1  system clock
iReset  in  1  asynchronous active-low reset
iStart  in  1  start request; sampled only while oReady=1
iTargetWay  in  NumberOfWays  one-hot (or multi-hot) way select; latched on start
iNumOfCycles  in  TimerWidth  hold length / timeout in cycles; latched on start; 0 treated as 1
iCEHold  in  1  1: assert CE of latched ways during hold; 0: all CE deasserted (standby); latched
iWaitRB  in  1  1: finish early when all latched ways' R/B# = 1; latched
iReadyBusy  in  NumberOfWays  raw R/B# per way (1 = ready), asynchronous
oReady  out  1  1 = idle, accepts iStart
oLastStep  out  1  one-cycle pulse in the final hold cycle
oTimeout  out  1  sticky: last RB-wait op expired on count; cleared on next accepted start
oDQSOutEnable  out  1  0 = drive (active-low enable)
oDQOutEnable  out  1  0 = drive
oDQStrobe  out  8  DQS pattern
oDQ  out  32  DQ pattern
oChipEnable  out  2*NumberOfWays  {ce, ce}, active-high per way in pinpad encoding
oReadEnable  out  4  RE pattern
oWriteEnable  out  4  WE pattern
oAddressLatchEnable  out  4  ALE pattern
oCommandLatchEnable  out  4  CLE pattern

Behaviour:
- Reset (iReset=0, asynchronous): state IDLE; oReady=1; oLastStep=0; oTimeout=0; counter=0; latched regs=0.
- Reset pin values: oChipEnable=0, oDQSOutEnable=0, oDQOutEnable=0, oDQStrobe=8'h00, oDQ=32'h0, oReadEnable=4'b0011, oWriteEnable=4'b0011 (Write_Idle), ALE=CLE=4'h0.
- Pin outputs are registered. In every state they equal the reset values, except oChipEnable = {ceWays, ceWays} during HOLD, where ceWays = latched iCEHold ? latchedWay : 0.
- States:
  - IDLE: oReady=1. iStart=1 latches way, count (0 -> 1), iCEHold and iWaitRB, clears oTimeout, and goes to HOLD.
  - HOLD: oReady=0. Counter decrements each cycle.
  - HOLD exit, count path: when counter==1, oLastStep=1 and next state is IDLE.
  - HOLD exit, RB path: in RB mode, when all synchronized R/B# bits of the latched ways are 1, oLastStep=1 in that cycle and next state is IDLE.
  - If both exit conditions hit in the same cycle, RB-ready wins and oTimeout stays 0.
  - If the count expires in RB mode without ready, set oTimeout=1.
- Latency, count mode: start accepted at edge t. CE is driven on cycles t+1..t+N. oLastStep is high on cycle t+N. oReady=1 and CE=0 from cycle t+N+1.
- RB early exit takes at least 1 hold cycle. R/B# synchronizer latency is RBSyncStages cycles, so readiness seen before start still counts.
- latchedWay=0 in RB mode is treated as ready: 1-cycle hold, no timeout.
- iStart while oReady=0 is ignored, and the latched values are unaffected. iStart held high re-triggers the cycle after oReady returns to 1.
- Inputs other than iStart and iReadyBusy are don't-care outside the start cycle.
- The counter never wraps. iNumOfCycles = all-ones gives 2^TimerWidth-1 hold cycles.
- Reset mid-HOLD: immediate return to IDLE with reset pin values. CE drops asynchronously.

Decomposition:
- Shared package/header: pin-encoding constants Write_Idle=4'b0011, Read_Idle=4'b0011, Out_Enable=0, Out_Disable=1, DQ/DQS idle values. These are shared with all NFC atoms.
- State encoding is local to this module.
- One natural sub-module: nfc_rb_synchronizer (RBSyncStages-deep flop chain per way, async active-low reset to 0).

Test Plan:
- Reset, then iStart with way=4'b0010, N=3, iCEHold=1, iWaitRB=0 -> oChipEnable=8'b00100010 for exactly 3 cycles; oLastStep high on cycle 3; oReady back to 1 on cycle 4.
- N=0 with iCEHold=0 -> 1-cycle hold, oChipEnable stays 0, oLastStep pulses once.
- RB mode, way=4'b0001, N=100, iReadyBusy[0] rises at cycle 10 -> oLastStep at cycle 10+RBSyncStages (±1); oTimeout=0.
- RB mode, N=20, R/B# held 0 -> exit after 20 cycles with oTimeout=1. The next accepted start clears oTimeout.
- iStart pulsed during HOLD with different way/N -> ignored, and the original op completes unchanged. iReset=0 mid-HOLD -> all outputs at reset values without waiting for a clock edge.
- way=4'b0101 in RB mode, only way 0 ready -> stays in HOLD; exits only once way 2 is also ready.
